// File: rtl/sync_to_ncl_tx.sv
// rtl/sync_to_ncl_tx.sv - single-rail valid/ready to dual-rail NCL token bridge
// Optional build macro: ACK_TIMEOUT_EN (16-bit ack timeout counter driving sticky err).
module sync_to_ncl_tx #(
    parameter int W           = 4,
    parameter     ENC         = "FP",
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_t,
    output logic [W-1:0] out_f,
    input  logic         ack_in,
    output logic         busy,
    output logic         err
);

    localparam bit IS_TP = (ENC == "TP");

    generate
        if (ENC != "FP" && ENC != "TP") begin : g_bad_enc
            $error("sync_to_ncl_tx: ENC must be \"FP\" or \"TP\"");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("sync_to_ncl_tx: SYNC_STAGES must be 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   ph, ph_d;
    logic                   ready_d;
    logic [W-1:0]           t_d, f_d;
    logic                   xfer;

    // ack_in is asynchronous to clk; only the last stage is ever looked at
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];
    assign xfer  = in_valid && in_ready;

    always_comb begin
        state_d = state;
        t_d     = out_t;
        f_d     = out_f;
        ready_d = in_ready;
        ph_d    = ph;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    ready_d = 1'b0;
                    if (IS_TP) begin
                        // one transition per bit: true rail for 1, false rail for 0
                        t_d     = out_t ^ in_data;
                        f_d     = out_f ^ ~in_data;
                        ph_d    = ~ph;
                        state_d = S_WAIT;
                    end else begin
                        t_d     = in_data;
                        f_d     = ~in_data;
                        state_d = S_DATA;
                    end
                end else begin
                    ready_d = IS_TP ? (ack_s == ph) : !ack_s;
                end
            end
            S_DATA: begin
                if (ack_s) begin
                    t_d     = '0;
                    f_d     = '0;
                    state_d = S_NULL;
                end
            end
            S_NULL: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (ack_s == ph) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                t_d     = '0;
                f_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            out_t    <= '0;
            out_f    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            ph       <= 1'b0;
        end else begin
            state    <= state_d;
            out_t    <= t_d;
            out_f    <= f_d;
            in_ready <= ready_d;
            busy     <= (state_d != S_IDLE);
            ph       <= ph_d;
        end
    end

`ifdef ACK_TIMEOUT_EN
    logic [15:0] to_cnt, to_cnt_d;

    // counts cycles spent waiting in one state; saturates so err stays meaningful
    always_comb begin
        to_cnt_d = to_cnt;
        if (state_d != state) begin
            to_cnt_d = '0;
        end else if (state != S_IDLE && to_cnt != 16'hFFFF) begin
            to_cnt_d = to_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            to_cnt <= to_cnt_d;
            if (to_cnt_d == 16'hFFFF) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_to_ncl_tx.sv
// tb/tb_sync_to_ncl_tx.sv - self-checking bench for sync_to_ncl_tx (FP and TP instances)
module tb_sync_to_ncl_tx;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int ST = 3;

    logic         clk;
    logic         rst_n;
    int           n_checks;
    int           n_errs;
    int           cyc;

    logic         fp_valid, fp_ready, fp_ack, fp_busy, fp_err;
    logic [W-1:0] fp_data, fp_t, fp_f;
    logic         tp_valid, tp_ready, tp_ack, tp_busy, tp_err;
    logic [W-1:0] tp_data, tp_t, tp_f;

    // 0: manual ack, 1: instant rails-complete loopback, 2: loopback delayed one clk
    int           ack_mode;
    logic         ack_man;
    logic         ack_comp, ack_comp_q;

    sync_to_ncl_tx #(.W(W), .ENC("FP"), .SYNC_STAGES(S)) dut_fp (
        .clk(clk), .rst(rst_n), .in_valid(fp_valid), .in_ready(fp_ready),
        .in_data(fp_data), .out_t(fp_t), .out_f(fp_f), .ack_in(fp_ack),
        .busy(fp_busy), .err(fp_err)
    );

    sync_to_ncl_tx #(.W(W), .ENC("TP"), .SYNC_STAGES(ST)) dut_tp (
        .clk(clk), .rst(rst_n), .in_valid(tp_valid), .in_ready(tp_ready),
        .in_data(tp_data), .out_t(tp_t), .out_f(tp_f), .ack_in(tp_ack),
        .busy(tp_busy), .err(tp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ack_comp = &(fp_t | fp_f);
    always @(posedge clk) ack_comp_q <= ack_comp;
    assign fp_ack = (ack_mode == 0) ? ack_man : (ack_mode == 1) ? ack_comp : ack_comp_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic [W-1:0] words [3];
    logic [W-1:0] m_w;
    logic [7:0]   exp_r;
    logic         exp_b, exp_rd, xfer, m_have;
    int           m_last, k, idx, phases, bh, dd;
    int           t_x [3];
    logic [7:0]   prev_r, cur_r;

    initial begin
        n_checks = 0; n_errs = 0; cyc = 0;
        ack_mode = 0; ack_man = 1'b0;
        fp_valid = 1'b0; fp_data = '0;
        tp_valid = 1'b0; tp_data = '0; tp_ack = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_fp", {fp_t, fp_f, fp_ready, fp_busy, fp_err}, 32'h0);
        chk("rst_tp", {tp_t, tp_f, tp_ready, tp_busy, tp_err}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", {fp_ready, tp_ready}, 32'h3);

        // FP single token, ack looped back one clk after rails complete
        ack_mode = 2;
        fp_data = 4'b1010; fp_valid = 1'b1;
        tick();
        fp_valid = 1'b0; fp_data = 4'b0111;
        chk("t1_data", {fp_t, fp_f, fp_busy, fp_ready}, {22'h0, 4'b1010, 4'b0101, 2'b10});
        for (int i = 1; i <= 2*S+4; i++) begin
            tick();
            exp_r  = (i < S+2) ? {4'b1010, 4'b0101} : 8'h00;
            exp_b  = (i < 2*S+4);
            exp_rd = (i >= 2*S+4);
            chk("t1_seq", {fp_t, fp_f, fp_busy, fp_ready}, {22'h0, exp_r, exp_b, exp_rd});
        end

        // FP back-to-back with in_valid held high and instant ack
        ack_mode = 1;
        words[0] = 4'hF; words[1] = 4'h0; words[2] = 4'h5;
        idx = 0; phases = 0; bh = 0; dd = 0; prev_r = 8'h00;
        fp_valid = 1'b1; fp_data = words[0];
        for (int c = 0; c < 40; c++) begin
            xfer = fp_valid && fp_ready;
            tick();
            if (xfer) begin
                t_x[idx] = cyc;
                idx++;
                if (idx < 3) fp_data = words[idx];
                else fp_valid = 1'b0;
            end
            cur_r = {fp_t, fp_f};
            if ((fp_t & fp_f) != 0) bh++;
            if (prev_r != 0 && cur_r != 0 && cur_r != prev_r) dd++;
            if (prev_r == 0 && cur_r != 0) begin
                if (phases < 3) chk("t2_word", cur_r, {24'h0, words[phases], ~words[phases]});
                phases++;
            end
            prev_r = cur_r;
        end
        chk("t2_xfers", idx, 3);
        chk("t2_phases", phases, 3);
        chk("t2_both_high", bh, 0);
        chk("t2_no_null", dd, 0);
        chk("t2_period0", t_x[1] - t_x[0], 2*S+3);
        chk("t2_period1", t_x[2] - t_x[1], 2*S+3);

        // TP two identical tokens, manual ack toggling
        tp_data = 4'b0011; tp_valid = 1'b1;
        tick();
        tp_valid = 1'b0; tp_data = 4'b1111;
        chk("tp1_rails", {tp_t, tp_f, tp_busy, tp_ready}, {22'h0, 4'b0011, 4'b1100, 2'b10});
        repeat (4) tick();
        chk("tp1_hold", {tp_t, tp_f, tp_ready}, {23'h0, 4'b0011, 4'b1100, 1'b0});
        tp_ack = 1'b1;
        for (int i = 1; i <= ST+1; i++) begin
            tick();
            chk("tp1_ready", {tp_ready, tp_busy}, (i == ST+1) ? 32'h2 : 32'h1);
        end
        tp_data = 4'b0011; tp_valid = 1'b1;
        tick();
        tp_valid = 1'b0;
        chk("tp2_rails", {tp_t, tp_f, tp_busy, tp_ready}, {22'h0, 8'h00, 2'b10});
        repeat (4) tick();
        chk("tp2_hold", tp_ready, 32'h0);
        tp_ack = 1'b0;
        for (int i = 1; i <= ST+1; i++) begin
            tick();
            chk("tp2_ready", tp_ready, (i == ST+1) ? 32'h1 : 32'h0);
        end

        // FP: sub-cycle ack glitches while in NULL must not release the token
        ack_mode = 0; ack_man = 1'b0;
        tick();
        fp_data = 4'b1100; fp_valid = 1'b1;
        tick();
        fp_valid = 1'b0;
        ack_man = 1'b1;
        repeat (S+1) tick();
        chk("gl_null", {fp_t, fp_f, fp_busy, fp_ready}, {22'h0, 8'h00, 2'b10});
        repeat (4) begin
            ack_man = 1'b0;
            #3;
            ack_man = 1'b1;
            tick();
        end
        chk("gl_hold", {fp_t, fp_f, fp_busy, fp_ready}, {22'h0, 8'h00, 2'b10});
        ack_man = 1'b0;
        for (int i = 1; i <= S+1; i++) begin
            tick();
            chk("gl_release", {fp_busy, fp_ready}, (i == S+1) ? 32'h1 : 32'h2);
        end

        // FP: asynchronous reset in the middle of DATA
        fp_data = 4'b0110; fp_valid = 1'b1;
        tick();
        fp_valid = 1'b0;
        chk("rm_data", {fp_t, fp_f}, {24'h0, 4'b0110, 4'b1001});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_async", {fp_t, fp_f, fp_ready, fp_busy}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rm_ready", {fp_ready, fp_busy}, 32'h2);

        // FP randomized traffic against an arithmetic timing model, instant ack
        ack_mode = 1;
        m_have = 1'b0; m_last = 0; m_w = '0; exp_rd = 1'b1;
        for (int c = 0; c < 400; c++) begin
            fp_valid = 1'($urandom_range(0, 1));
            fp_data  = W'($urandom);
            xfer = fp_valid && exp_rd;
            if (xfer) m_w = fp_data;
            tick();
            if (xfer) begin
                m_have = 1'b1;
                m_last = cyc;
            end
            k      = cyc - m_last;
            exp_r  = (m_have && k < S+1) ? {m_w, ~m_w} : 8'h00;
            exp_b  = m_have && (k < 2*S+2);
            exp_rd = !m_have || (k >= 2*S+2);
            chk("rnd", {fp_t, fp_f, fp_busy, fp_ready}, {22'h0, exp_r, exp_b, exp_rd});
        end
        fp_valid = 1'b0;
        repeat (2*S+3) tick();

        // ack never arrives: err depends on the timeout build option
        ack_mode = 0; ack_man = 1'b0;
        tick();
        fp_data = 4'b1001; fp_valid = 1'b1;
        tick();
        fp_valid = 1'b0;
`ifdef ACK_TIMEOUT_EN
        repeat (65534) tick();
        chk("to_before", fp_err, 32'h0);
        tick();
        chk("to_err", fp_err, 32'h1);
        repeat (10) tick();
        chk("to_sticky", fp_err, 32'h1);
`else
        repeat (300) tick();
        chk("to_err", fp_err, 32'h0);
`endif
        chk("to_rails", {fp_t, fp_f, fp_busy}, {23'h0, 4'b1001, 4'b0110, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sync_to_ncl_tx.md
Name: sync_to_ncl_tx

Overview:
- Clocked-to-delay-insensitive bridge directly upstream of the threshold-gate (TH_XY) pipeline.
- Takes single-rail words on a valid/ready handshake and emits dual-rail tokens (out_t/out_f) into the gate network.
- Paces tokens on the network's completion signal ack_in, which is double-synchronised into clk.
- Supports four-phase return-to-NULL (ENC "FP") and two-phase transition signalling (ENC "TP"), matching the gate library's encodings.

Parameters:
- W, 4: data width, one dual-rail pair per bit.
- ENC, "FP": "FP" = four-phase RZ (DATA then NULL); "TP" = two-phase, no NULL spacer.
- SYNC_STAGES, 2: ack_in synchroniser depth; legal values 2..4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  sync-side word valid
- in_ready  output  1  sync-side ready; transfer when in_valid && in_ready at a rising clk edge
- in_data  input  W  single-rail word
- out_t  output  W  true rails into gate network
- out_f  output  W  false rails into gate network
- ack_in  input  1  completion from downstream gate network (asynchronous)
- busy  output  1  token in flight (state != IDLE)
- err  output  1  ack timeout sticky flag (only with ACK_TIMEOUT_EN; tied 0 otherwise)

Behaviour:
- All outputs are registered.
- ack_s = ack_in after SYNC_STAGES flops. All decisions use ack_s only.
- Reset (rst low, async): out_t=0, out_f=0, in_ready=0, busy=0, err=0, state=IDLE, synchroniser flops=0, TP expected-ack phase ph=0.
- After release, in_ready rises on the first edge where IDLE and the ack condition holds:
  - FP: ack_s==0.
  - TP: ack_s==ph.
- FP state machine, states IDLE, DATA, NULL:
  - IDLE: in_ready=1 while ack_s==0. On transfer at edge N: at N+1, out_t=in_data, out_f=~in_data, in_ready=0, busy=1, state→DATA.
  - DATA: hold rails until ack_s==1. On the edge where ack_s==1 is sampled: rails → all 0, state→NULL.
  - NULL: hold all-zero rails until ack_s==0. Then state→IDLE, busy=0, in_ready=1 on that same edge.
  - Latency transfer→rails valid: 1 cycle.
  - Minimum token period: 2*SYNC_STAGES+3 cycles, with ack_in responding instantly.
- TP state machine, states IDLE, WAIT:
  - On transfer: per bit, out_t[i] toggles if in_data[i]=1, else out_f[i] toggles. ph inverts. State→WAIT, busy=1, in_ready=0.
  - WAIT: when ack_s==ph, state→IDLE and in_ready=1.
  - Minimum token period: SYNC_STAGES+2 cycles.
- No rail ever changes outside the transitions above.
  - FP: never DATA→DATA without NULL between.
  - FP: never both rails of a bit high.
- in_data is captured only on transfer; changes at other times are ignored.
- in_valid held low: outputs hold indefinitely in any state.
- ack_in glitching is tolerated only through the synchroniser. A premature ack_s (FP ack_s==1 while in NULL) is ignored; the FSM waits for the required level.
- Reset mid-token: rails drop to 0 immediately (async). Downstream must be reset concurrently; this is a system requirement.
- Illegal ENC value: elaboration error via generate-time $error.

Optional Feature:
- ACK_TIMEOUT_EN defined:
  - 16-bit counter clears on every state change and increments each cycle in DATA/NULL/WAIT.
  - Reaching 16'hFFFF sets err=1 (sticky until reset). The FSM keeps waiting; no recovery action.
- Undefined: no counter; err tied 0.

Test Plan:
- FP, W=4, ack_in loops back rails-complete after 1 cycle; send 4'b1010 → out_t=1010, out_f=0101 one cycle after transfer. Then all-zero rails after ack_s rises; in_ready returns 1 after ack_s falls; busy high throughout.
- FP back-to-back words 0xF, 0x0, 0x5 with in_valid held high → exactly 3 DATA phases each separated by an all-zero NULL. Period = 2*SYNC_STAGES+3 cycles. No bit with both rails high at any cycle.
- TP, W=4, from reset send 4'b0011 then 4'b0011 → after first: out_t=0011, out_f=1100. After second: out_t=0000, out_f=0000. in_ready low until ack_in toggles each time.
- Assert rst low while in FP DATA with out_t=0110 → out_t/out_f=0, in_ready=0 within the same cycle, no clk needed. After release, in_ready=1 once ack_s==0.
- Hold ack_in=0 forever after a transfer with ACK_TIMEOUT_EN defined → err=1 after 65535 cycles in DATA; rails unchanged. Without the macro → err stays 0.
- Pulse ack_in high for less than 1 clk period while in FP NULL → no state change; FSM stays in NULL until a stable low is sampled.
